// File: rtl/sseg_scan_decoder.sv
// Passive monitor for a multiplexed 4-digit active-low 7-segment bus.
// Captures settled digits, checks two matching frames, then publishes the value in binary and BCD.
module sseg_scan_decoder #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  sseg_indicator,
   input  logic [3:0]  digits,
   output logic [8:0]  address_line,
   output logic [11:0] bcd_value,
   output logic        address_valid,
   output logic        overflow,
   output logic        decode_error
);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_CHECK   = 2'd1,
      ST_CONV    = 2'd2,
      ST_OUT     = 2'd3
   } state_t;

   localparam logic [7:0] CAP_AT = 8'(SETTLE_CYCLES - 2);
   localparam logic [7:0] SAT    = 8'(SETTLE_CYCLES - 1);

   // Returns {valid, digit}; the decimal point bit is a don't-care.
   function automatic logic [4:0] seg_decode(input logic [7:0] seg);
      logic [4:0] r;
      casez (seg)
         8'b?100_0000: r = 5'h10;
         8'b?111_1001: r = 5'h11;
         8'b?010_0100: r = 5'h12;
         8'b?011_0000: r = 5'h13;
         8'b?001_1001: r = 5'h14;
         8'b?001_0010: r = 5'h15;
         8'b?000_0010: r = 5'h16;
         8'b?111_1000: r = 5'h17;
         8'b?000_0000: r = 5'h18;
         8'b?001_0000: r = 5'h19;
         default:      r = 5'h00;
      endcase
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  digits_q;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;
   logic        have_ones_q, have_ones_d, have_tens_q, have_tens_d;
   logic [11:0] prev_q, prev_d;
   logic        prev_valid_q, prev_valid_d;
   logic [8:0]  addr_q, addr_d;
   logic [11:0] bcd_q, bcd_d;
   logic        ovf_q, ovf_d, valid_q, valid_d, err_q, err_d;

   logic        onehot_s, stable_s, capture_s, dec_ok_s;
   logic [4:0]  dec_s;
   logic [3:0]  dec_val_s;
   logic [9:0]  h_ext_s, t_ext_s, o_ext_s, sum_s;

   // Strobe settle counter: one capture per stable one-hot strobe period.
   always_comb begin
      onehot_s  = (digits != 4'd0) && ((digits & (digits - 4'd1)) == 4'd0);
      stable_s  = onehot_s && (digits == digits_q);
      capture_s = stable_s && (cnt_q == CAP_AT);
      if (!stable_s) begin
         cnt_d = 8'd0;
      end else if (cnt_q == SAT) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
      dec_s     = seg_decode(sseg_indicator);
      dec_ok_s  = dec_s[4];
      dec_val_s = dec_s[3:0];
      h_ext_s   = {6'd0, hund_q};
      t_ext_s   = {6'd0, tens_q};
      o_ext_s   = {6'd0, ones_q};
      sum_s     = (h_ext_s << 6) + (h_ext_s << 5) + (h_ext_s << 2)
                + (t_ext_s << 3) + (t_ext_s << 1) + o_ext_s;
   end

   // Frame assembly, repeat check and conversion sequencing.
   always_comb begin
      state_d      = state_q;
      ones_d       = ones_q;
      tens_d       = tens_q;
      hund_d       = hund_q;
      have_ones_d  = have_ones_q;
      have_tens_d  = have_tens_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      addr_d       = addr_q;
      bcd_d        = bcd_q;
      ovf_d        = ovf_q;
      valid_d      = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            if (capture_s && !digits[3]) begin
               if (!dec_ok_s) begin
                  err_d        = 1'b1;
                  have_ones_d  = 1'b0;
                  have_tens_d  = 1'b0;
                  prev_valid_d = 1'b0;
               end else begin
                  case (digits)
                     4'b0001: begin
                        ones_d      = dec_val_s;
                        have_ones_d = 1'b1;
                        have_tens_d = 1'b0;
                     end
                     4'b0010: begin
                        if (have_ones_q && !have_tens_q) begin
                           tens_d      = dec_val_s;
                           have_tens_d = 1'b1;
                        end else begin
                           have_ones_d = 1'b0;
                           have_tens_d = 1'b0;
                        end
                     end
                     4'b0100: begin
                        have_ones_d = 1'b0;
                        have_tens_d = 1'b0;
                        if (have_tens_q) begin
                           hund_d  = dec_val_s;
                           state_d = ST_CHECK;
                        end else begin
                           state_d = ST_COLLECT;
                        end
                     end
                     default: begin
                        state_d = ST_COLLECT;
                     end
                  endcase
               end
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_CHECK: begin
            if (prev_valid_q && (prev_q == {hund_q, tens_q, ones_q})) begin
               state_d = ST_CONV;
            end else begin
               prev_d       = {hund_q, tens_q, ones_q};
               prev_valid_d = 1'b1;
               state_d      = ST_COLLECT;
            end
         end
         // Results are loaded here so they are visible during the OUT cycle.
         ST_CONV: begin
            addr_d  = sum_s[8:0];
            bcd_d   = {hund_q, tens_q, ones_q};
            ovf_d   = (sum_s > 10'd511);
            valid_d = 1'b1;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            state_d = ST_COLLECT;
         end
         default: begin
            state_d = ST_COLLECT;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_COLLECT;
         digits_q     <= 4'd0;
         cnt_q        <= 8'd0;
         ones_q       <= 4'd0;
         tens_q       <= 4'd0;
         hund_q       <= 4'd0;
         have_ones_q  <= 1'b0;
         have_tens_q  <= 1'b0;
         prev_q       <= 12'd0;
         prev_valid_q <= 1'b0;
         addr_q       <= 9'd0;
         bcd_q        <= 12'd0;
         ovf_q        <= 1'b0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         digits_q     <= digits;
         cnt_q        <= cnt_d;
         ones_q       <= ones_d;
         tens_q       <= tens_d;
         hund_q       <= hund_d;
         have_ones_q  <= have_ones_d;
         have_tens_q  <= have_tens_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         addr_q       <= addr_d;
         bcd_q        <= bcd_d;
         ovf_q        <= ovf_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
      end
   end

   assign address_line  = addr_q;
   assign bcd_value     = bcd_q;
   assign address_valid = valid_q;
   assign overflow      = ovf_q;
   assign decode_error  = err_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench: a frame-level model queues expected publishes/errors, a monitor checks them.
module tb_sseg_scan_decoder;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  sseg;
   logic [3:0]  digits;
   logic [8:0]  address_line;
   logic [11:0] bcd_value;
   logic        address_valid, overflow, decode_error;

   sseg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .sseg_indicator(sseg), .digits(digits),
      .address_line(address_line), .bcd_value(bcd_value),
      .address_valid(address_valid), .overflow(overflow), .decode_error(decode_error)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int val;} pub_t;
   pub_t pub_q[$];
   int   err_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   prev_val = -1;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic [6:0] bad_tab [4]  = '{7'h7F, 7'h3F, 7'h01, 7'h55};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int to_bcd(input int v);
      return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
   endfunction

   // Monitor: every pulse from the DUT must match the head of its queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (address_valid) begin
            if (pub_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_publish actual=%0d expected=none", address_line);
            end else begin
               pub_t e;
               e = pub_q.pop_front();
               check("publish_cycle", cyc, e.cyc);
               check("address_line", int'(address_line), e.val % 512);
               check("bcd_value", int'(bcd_value), to_bcd(e.val));
               check("overflow", int'(overflow), (e.val > 511) ? 1 : 0);
            end
         end
         if (decode_error) begin
            if (err_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_decode_error actual=1 expected=0 cycle=%0d", cyc);
            end else begin
               check("decode_error_cycle", cyc, err_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input logic [3:0] dg, input logic [7:0] sg, input int hold);
      digits = dg;
      sseg   = sg;
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One scan frame ones->tens->hundreds->unused; bad_pos>=0 corrupts that position.
   task automatic send_frame(input int val, input int bad_pos, input logic [6:0] bad_pat,
                             input int hold);
      int d;
      logic [6:0] pat;
      for (int p = 0; p < 3; p++) begin
         d   = (p == 0) ? val % 10 : (p == 1) ? (val / 10) % 10 : val / 100;
         pat = (p == bad_pos) ? bad_pat : seg_tab[d];
         if (p == bad_pos) err_q.push_back(cyc + S);
         if (p == 2 && bad_pos < 0) begin
            if (prev_val == val) pub_q.push_back('{cyc + S + 2, val});
            else prev_val = val;
         end
         drive(4'(4'b0001 << p), {1'($urandom_range(0, 1)), pat}, hold);
      end
      if (bad_pos >= 0) prev_val = -1;
      drive(4'b1000, 8'hFF, hold);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_address_line"}, int'(address_line), 0);
      check({tag, "_bcd_value"}, int'(bcd_value), 0);
      check({tag, "_address_valid"}, int'(address_valid), 0);
      check({tag, "_overflow"}, int'(overflow), 0);
      check({tag, "_decode_error"}, int'(decode_error), 0);
   endtask

   initial begin
      int val, last, bad_pos, hold;
      reset  = 1'b1;
      digits = 4'd0;
      sseg   = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b0;
      drive(4'd0, 8'hFF, 2);

      repeat (3) send_frame(123, -1, 7'h00, 9);
      send_frame(45, -1, 7'h00, 9);
      send_frame(46, -1, 7'h00, 9);
      send_frame(46, -1, 7'h00, 9);
      send_frame(200, -1, 7'h00, 9);
      send_frame(200, 1, 7'h7F, 9);
      send_frame(200, -1, 7'h00, 9);
      send_frame(200, -1, 7'h00, 9);
      send_frame(999, -1, 7'h00, 9);
      send_frame(999, -1, 7'h00, 9);
      send_frame(5, -1, 7'h00, 9);
      send_frame(5, -1, 7'h00, 9);

      // Glitches: short strobes, multi-hot strobe, blanked unused position.
      for (int p = 0; p < 3; p++) drive(4'(4'b0001 << p), {1'b1, seg_tab[7]}, 3);
      drive(4'b0011, {1'b1, seg_tab[1]}, 9);
      drive(4'b1000, 8'hFF, 9);

      // Reset between frame-1 and frame-2 hundreds captures of 321.
      send_frame(321, -1, 7'h00, 9);
      drive(4'b0001, {1'b1, seg_tab[1]}, 9);
      drive(4'b0010, {1'b1, seg_tab[2]}, 9);
      digits = 4'b0100;
      sseg   = {1'b1, seg_tab[3]};
      reset  = 1'b1;
      #1;
      check_zero("midreset");
      prev_val = -1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(4'b0100, {1'b1, seg_tab[3]}, 8);
      drive(4'b1000, 8'hFF, 9);
      send_frame(321, -1, 7'h00, 9);
      send_frame(321, -1, 7'h00, 9);

      last = -1;
      for (int i = 0; i < 30; i++) begin
         val     = ($urandom_range(0, 1) == 1 && last >= 0) ? last : int'($urandom_range(0, 999));
         bad_pos = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
         hold    = int'($urandom_range(S, S + 8));
         send_frame(val, bad_pos, bad_tab[$urandom_range(0, 3)], hold);
         last = val;
      end

      drive(4'd0, 8'hFF, 10);
      check("pending_publishes", pub_q.size(), 0);
      check("pending_errors", err_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Passive reader for a multiplexed 4-digit, active-low 7-segment bus: it samples the segment and digit-strobe lines and recovers the 3-digit decimal value being displayed. It then publishes that value as binary with a one-cycle valid strobe. It sits on the far side of the address display bus and serves as a board-level self-check and bench monitor for the ROM address shown to the operator.

## Interface

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles a digit strobe must be stable before its segments are captured. Legal range is 4..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sseg_indicator  in  8  segment lines, active-low; bit 7 is the decimal point and is ignored; bits [6:0] are g..a.
- digits  in  4  digit strobes, one-hot: 0001 ones, 0010 tens, 0100 hundreds, 1000 unused position.
- address_line  out  9  recovered value, bits [8:0] of h*100+t*10+o.
- bcd_value  out  12  recovered BCD value {h,t,o}.
- address_valid  out  1  one-cycle pulse when address_line/bcd_value update.
- overflow  out  1  set with each publish when the decimal value > 511; cleared by the next publish ≤ 511.
- decode_error  out  1  one-cycle pulse on an unrecognised segment pattern.

## Operation

- **Strobe tracking.**
  - A settle counter increments while `digits` equals its previous-cycle value and is one-hot.
  - The counter clears on any change or on a non-one-hot value (0000 or multi-hot).
  - A capture fires exactly once per strobe period, in the cycle the counter reaches SETTLE_CYCLES-1, i.e. the SETTLE_CYCLES-th stable cycle.
  - The counter saturates after a capture; there are no repeat captures.
- **Segment decode.** Match [6:0] against this table; anything else is invalid:
  - 0 → 0x40, 1 → 0x79, 2 → 0x24, 3 → 0x30, 4 → 0x19
  - 5 → 0x12, 6 → 0x02, 7 → 0x78, 8 → 0x00, 9 → 0x10
- **Strobe 1000.** Captures on the unused position are ignored entirely, with no error.
- **States.**
  - COLLECT.
    - Expects captures in the order ones → tens → hundreds.
    - An out-of-order capture discards the partial frame. If that capture is a ones capture, it starts a new frame.
    - An invalid pattern pulses decode_error, discards the partial frame and invalidates the previous-frame register.
    - A valid hundreds capture completing the frame → CHECK.
  - CHECK (1 cycle).
    - If the previous-frame register is valid and equals the new frame → CONV.
    - Otherwise store the new frame as previous (mark it valid) → COLLECT.
  - CONV (1 cycle). Register h*100 + t*10 + o using shift-adds: h*64+h*32+h*4 and t*8+t*2. The sum is 10 bits wide (max 999).
  - OUT (1 cycle).
    - address_valid=1; address_line=sum[8:0]; bcd_value={h,t,o}; overflow=(sum>511).
    - The previous-frame register stays valid, so each further identical frame republishes.
    - → COLLECT.
- **Captures outside COLLECT.** Captures in CHECK/CONV/OUT are dropped. With SETTLE_CYCLES ≥ 4, no capture can fall in these states during nominal scanning.

## Timing

- **Reset values.**
  - address_line=0, bcd_value=0, address_valid=0, overflow=0, decode_error=0.
  - State COLLECT, settle counter 0, partial frame empty, previous-frame register invalid.
- **Reset mid-operation.** Everything returns to the reset values immediately (asynchronous). Two complete matching frames are needed after release before the next publish.
- **Latency.** With the hundreds capture at cycle N: CHECK at N+1, CONV at N+2, address_valid high during N+3 only.
- **decode_error timing.** decode_error is high in the cycle after the offending capture, for one cycle.
- **Output hold.** address_line, bcd_value and overflow hold between publishes.
- **Minimum publish interval.** One full scan frame.

## Test plan

- Scan "123" at 9 cycles per digit, SETTLE_CYCLES=4, three frames:
  - no pulse after frame 1;
  - address_valid pulses 3 cycles after the frame-2 hundreds capture with address_line=123, bcd_value=0x123, overflow=0;
  - it pulses again after frame 3.
- Frames 45, 46, 46: no publish on the 45→46 mismatch; publish after the second 46 with address_line=46.
- Tens segments = 0xFF in frame 2 of "200": decode_error pulses once; the first publish comes after two further clean frames, with address_line=200.
- Scan "999" twice: address_line=487, bcd_value=0x999, overflow=1; then scan "5" twice: overflow=0, address_line=5.
- Strobe glitches: each digit held only 3 cycles produces no captures; `digits`=0011 is ignored; a strobe 1000 carrying 0xFF produces no error; none of these produce a publish.
- Assert reset between the frame-1 and frame-2 hundreds captures of "321": all outputs go to 0 at once; after release, the publish occurs only after two complete new frames.
